// File: rtl/io_response_interface.sv
// io_response_interface
//   Return path of the IO port. Takes one full-width read response from the
//   port and replays it to the core as DATABITWIDTH-wide beats over a
//   valid/ready handshake. Sub-word loads are lane-extracted and zero/sign
//   extended into a single beat; word-or-larger loads stream words WI..last.
//   Optional feature macro: IO_RESPONSE_PREFETCH_EN adds a second holding
//   buffer so the next response can be accepted while the current one streams.
module io_response_interface #(
   parameter int DATABITWIDTH  = 16,
   parameter int PORTBYTEWIDTH = 8,
   parameter int TAGBITWIDTH   = 4
) (
   input  logic                       clk,
   input  logic                       async_rst_n,
   input  logic                       clk_en,
   input  logic                       RespInACK,
   output logic                       RespInREQ,
   input  logic [3:0]                 MinorOpcodeIn,
   input  logic [DATABITWIDTH-1:0]    DataAddrIn,
   input  logic [PORTBYTEWIDTH*8-1:0] DataIn,
   input  logic [TAGBITWIDTH-1:0]     TagIn,
   output logic                       RespOutACK,
   input  logic                       RespOutREQ,
   output logic [DATABITWIDTH-1:0]    DataOut,
   output logic [DATABITWIDTH-1:0]    DataAddrOut,
   output logic [TAGBITWIDTH-1:0]     TagOut,
   output logic                       LastOut
);

   localparam int PBITS       = PORTBYTEWIDTH * 8;
   localparam int BUFFERCOUNT = (PBITS <= DATABITWIDTH) ? 1 : PBITS / DATABITWIDTH;
   localparam int DBYTES      = DATABITWIDTH / 8;
   localparam int WIDX        = (DBYTES > 1) ? $clog2(DBYTES) : 1;
   localparam int BIDX        = (BUFFERCOUNT > 1) ? $clog2(BUFFERCOUNT) : 1;
   localparam int BUFW        = BUFFERCOUNT * DATABITWIDTH;
   localparam logic [BIDX-1:0] LAST_IDX = BIDX'(BUFFERCOUNT - 1);

   typedef enum logic {IDLE, SEND} state_t;

   // Start word of an access; a single-word buffer always starts at word 0.
   function automatic logic [BIDX-1:0] start_word(input logic [DATABITWIDTH-1:0] addr);
      if (BUFFERCOUNT == 1) return '0;
      return addr[WIDX+BIDX-1:WIDX];
   endfunction

   // Opcode bit 3 carries no meaning on the return path.
   logic op_unused;
   assign op_unused = MinorOpcodeIn[3];

   state_t                  state_q, state_d;
   logic [BUFW-1:0]         buf_q, buf_d;
   logic [DATABITWIDTH-1:0] addr_q, addr_d;
   logic [TAGBITWIDTH-1:0]  tag_q, tag_d;
   logic [2:0]              op_q, op_d;
   logic [BIDX-1:0]         idx_q, idx_d;
`ifdef IO_RESPONSE_PREFETCH_EN
   logic [BUFW-1:0]         hold_buf_q, hold_buf_d;
   logic [DATABITWIDTH-1:0] hold_addr_q, hold_addr_d;
   logic [TAGBITWIDTH-1:0]  hold_tag_q, hold_tag_d;
   logic [2:0]              hold_op_q, hold_op_d;
   logic                    hold_valid_q, hold_valid_d;
`endif

   logic                    in_hs, out_hs;
   logic [3:0]              size_bytes;
   int                      field_bits;
   logic                    sub_word;
   logic [DATABITWIDTH-1:0] word_sel, shifted, sub_data;
   logic [WIDX-1:0]         lb_aligned;
   logic                    sign_bit;

`ifdef IO_RESPONSE_PREFETCH_EN
   assign RespInREQ = !hold_valid_q;
`else
   assign RespInREQ = (state_q == IDLE);
`endif
   assign RespOutACK = (state_q == SEND);
   assign in_hs      = RespInACK && RespInREQ && clk_en;
   assign out_hs     = RespOutACK && RespOutREQ && clk_en;

   // Select the current word and locate the size-aligned lane for sub-word loads.
   always_comb begin
      size_bytes = 4'd1 << op_q[1:0];
      field_bits = int'(size_bytes) * 8;
      sub_word   = int'(size_bytes) < DBYTES;
      word_sel   = buf_q[int'(idx_q)*DATABITWIDTH +: DATABITWIDTH];
      lb_aligned = addr_q[WIDX-1:0] & ~WIDX'(size_bytes - 4'd1);
      shifted    = word_sel >> (int'(lb_aligned) * 8);
      sign_bit   = 1'b0;
      for (int i = 0; i < DATABITWIDTH; i++) begin
         if (i == field_bits - 1) sign_bit = shifted[i];
      end
   end

   // Bits above the field width are filled with zero or the field's sign bit.
   generate
      for (genvar gi = 0; gi < DATABITWIDTH; gi++) begin : g_ext
         assign sub_data[gi] = (gi < field_bits) ? shifted[gi] : (op_q[2] & sign_bit);
      end
   endgenerate

   // Beat outputs are driven straight from the active buffer so they hold while stalled.
   always_comb begin
      DataOut     = sub_word ? sub_data : word_sel;
      DataAddrOut = sub_word ? addr_q
                             : {addr_q[DATABITWIDTH-1:WIDX+BIDX], idx_q, {WIDX{1'b0}}};
      TagOut      = tag_q;
      LastOut     = (state_q == SEND) && (sub_word || (idx_q == LAST_IDX));
   end

   // Next-state: beat advance, end of response, and routing of accepted responses.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      addr_d  = addr_q;
      tag_d   = tag_q;
      op_d    = op_q;
      idx_d   = idx_q;
`ifdef IO_RESPONSE_PREFETCH_EN
      hold_buf_d   = hold_buf_q;
      hold_addr_d  = hold_addr_q;
      hold_tag_d   = hold_tag_q;
      hold_op_d    = hold_op_q;
      hold_valid_d = hold_valid_q;
`endif

      if (out_hs && !LastOut) idx_d = idx_q + 1'b1;

`ifdef IO_RESPONSE_PREFETCH_EN
      if (out_hs && LastOut) begin
         if (hold_valid_q) begin
            // Promote the held response so its first beat follows with no bubble.
            buf_d        = hold_buf_q;
            addr_d       = hold_addr_q;
            tag_d        = hold_tag_q;
            op_d         = hold_op_q;
            idx_d        = start_word(hold_addr_q);
            hold_valid_d = 1'b0;
            state_d      = SEND;
         end else if (in_hs) begin
            buf_d   = BUFW'(DataIn);
            addr_d  = DataAddrIn;
            tag_d   = TagIn;
            op_d    = MinorOpcodeIn[2:0];
            idx_d   = start_word(DataAddrIn);
            state_d = SEND;
         end else begin
            state_d = IDLE;
         end
      end else if (in_hs) begin
         if (state_q == IDLE) begin
            buf_d   = BUFW'(DataIn);
            addr_d  = DataAddrIn;
            tag_d   = TagIn;
            op_d    = MinorOpcodeIn[2:0];
            idx_d   = start_word(DataAddrIn);
            state_d = SEND;
         end else begin
            hold_buf_d   = BUFW'(DataIn);
            hold_addr_d  = DataAddrIn;
            hold_tag_d   = TagIn;
            hold_op_d    = MinorOpcodeIn[2:0];
            hold_valid_d = 1'b1;
         end
      end
`else
      if (out_hs && LastOut) begin
         state_d = IDLE;
      end else if (in_hs) begin
         buf_d   = BUFW'(DataIn);
         addr_d  = DataAddrIn;
         tag_d   = TagIn;
         op_d    = MinorOpcodeIn[2:0];
         idx_d   = start_word(DataAddrIn);
         state_d = SEND;
      end
`endif
   end

   // State and buffer registers; reset clears everything so no beat survives it.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_q <= IDLE;
         buf_q   <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
         op_q    <= '0;
         idx_q   <= '0;
`ifdef IO_RESPONSE_PREFETCH_EN
         hold_buf_q   <= '0;
         hold_addr_q  <= '0;
         hold_tag_q   <= '0;
         hold_op_q    <= '0;
         hold_valid_q <= 1'b0;
`endif
      end else if (clk_en) begin
         state_q <= state_d;
         buf_q   <= buf_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
`ifdef IO_RESPONSE_PREFETCH_EN
         hold_buf_q   <= hold_buf_d;
         hold_addr_q  <= hold_addr_d;
         hold_tag_q   <= hold_tag_d;
         hold_op_q    <= hold_op_d;
         hold_valid_q <= hold_valid_d;
`endif
      end
   end

endmodule
